// File: rtl/param_add_accum.sv
// Registered add/sub/accumulate unit with valid/ready on both sides and an accepted-op counter.
// Define SAT_ARITH_EN to saturate ADD/ACC overflow to all-ones and SUB underflow to zero.
module param_add_accum #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             accept;
  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] res;
  logic             carry;

`ifdef SAT_ARITH_EN
  // Bit WIDTH of the raw sum is carry for ADD/ACC and borrow for SUB.
  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH:0] r, input logic [1:0] op);
    if (!r[WIDTH])
      return r[WIDTH-1:0];
    if (op == OP_SUB || op == OP_CLR)
      return '0;
    return '1;
  endfunction
`endif

  assign out_valid = (state == FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;

  always_comb begin
    raw = '0;
    case (in_op)
      OP_ADD:  raw = {1'b0, in_a} + {1'b0, in_b};
      OP_SUB:  raw = {1'b0, in_a} - {1'b0, in_b};
      OP_ACC:  raw = {1'b0, acc} + {1'b0, in_a};
      default: raw = '0;
    endcase
    carry = raw[WIDTH];
`ifdef SAT_ARITH_EN
    res = sat_result(raw, in_op);
`else
    res = raw[WIDTH-1:0];
`endif
  end

  // Output register stage: load on accept, drain on out_ready with no new accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b1;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (out_ready && !accept) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (accept) begin
        out_result <= res;
        out_carry  <= carry;
        out_zero   <= (res == '0);
        op_count   <= op_count + CNT_ONE;
        if (in_op == OP_ACC)
          acc <= res;
        else if (in_op == OP_CLR)
          acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_param_add_accum.sv
// Directed bench for param_add_accum at WIDTH=4, CNT_W=8, wrap or saturating build.
module tb_param_add_accum;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
`ifdef SAT_ARITH_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  param_add_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero),
    .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one op for a single cycle; caller guarantees in_ready.
  task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_cnt++;
  endtask

  task automatic chk_out(input string tag, input int res, input int cy, input int zr);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, out_result, res);
    chk({tag, "_carry"}, out_carry, cy);
    chk({tag, "_zero"}, out_zero, zr);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_result"}, out_result, 0);
    chk({tag, "_carry"}, out_carry, 0);
    chk({tag, "_zero"}, out_zero, 1);
    chk({tag, "_cnt"}, op_count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = ADD;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    reset = 1'b0;

    // Basic arithmetic
    do_op(ADD, 4'd9, 4'd8);
    chk_out("add98", SAT ? 15 : 1, 1, 0);
    do_op(SUB, 4'd3, 4'd5);
    chk_out("sub35", SAT ? 0 : 14, 1, SAT ? 1 : 0);
    do_op(CLR, 4'd7, 4'd7);
    chk_out("clr", 0, 0, 1);
    do_op(ACC, 4'd5, 4'd9);
    chk_out("acc5", 5, 0, 0);
    do_op(ACC, 4'd7, 4'd9);
    chk_out("acc7", 12, 0, 0);
    do_op(ACC, 4'd6, 4'd9);
    chk_out("acc6", SAT ? 15 : 2, 1, 0);
    do_op(ACC, 4'd0, 4'd0);
    chk_out("acc_rd", SAT ? 15 : 2, 0, 0);
    do_op(ADD, 4'd1, 4'd1);
    chk_out("add11", 2, 0, 0);
    do_op(ACC, 4'd0, 4'd0);
    chk_out("acc_keep", SAT ? 15 : 2, 0, 0);
    chk("cnt_basic", op_count, exp_cnt);

    // Drain: no new op with out_ready=1 empties the register
    @(posedge clk); #1;
    chk("drain_valid", out_valid, 0);

    // Backpressure
    out_ready = 1'b0;
    do_op(ADD, 4'd2, 4'd3);
    chk_out("bp_load", 5, 0, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_op = 2'(i); in_a = 4'(i); in_b = 4'(15 - i);
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", out_result, 5);
      chk("bp_valid", out_valid, 1);
    end
    in_a = 'x; in_b = 'x; in_op = 'x;
    @(posedge clk); #1;
    chk("bpx_result", out_result, 5);
    chk("bpx_cnt", op_count, exp_cnt);
    in_op = ADD; in_a = 4'd4; in_b = 4'd6;
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_cnt++;
    chk_out("bp_b2b", 10, 0, 0);
    chk("bp_cnt", op_count, exp_cnt);

    // Async reset mid-stream with acc=12, op_count=7, out_valid=1
    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 0;
    do_op(CLR, 4'd0, 4'd0);
    do_op(ACC, 4'd5, 4'd0);
    do_op(ACC, 4'd7, 4'd0);
    for (int i = 0; i < 4; i++) do_op(ADD, 4'd9, 4'd8);
    chk("pre_rst_cnt", op_count, 7);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = 0;
    do_op(ACC, 4'd1, 4'd0);
    chk_out("post_rst_acc", 1, 0, 0);
    chk("post_rst_cnt", op_count, 1);

    // Counter wrap
    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = ADD; in_a = 4'd1; in_b = 4'd2;
    for (int i = 0; i < 255; i++) @(posedge clk);
    #1;
    chk("cnt_255", op_count, 255);
    @(posedge clk); #1;
    chk("cnt_wrap0", op_count, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("cnt_wrap1", op_count, 1);
    chk_out("wrap_add", 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
